// File: rtl/vga_timing_if.sv
// VGA timing bundle: everything the timing generator presents to pixel and game logic.
//   master : driven by vga_timing_gen
//   slave  : consumers (pixel pipeline, game logic, testbench)
// Signals: pix_ce, hcount, vcount, hsync, vsync, bright, x, y, line_start, frame_start,
// plus frame_count[15:0] when VGA_TIMING_FRAME_CNT_EN is defined.
interface vga_timing_if #(
  parameter int unsigned CNT_W = 10
);
  logic             pix_ce;
  logic [CNT_W-1:0] hcount;
  logic [CNT_W-1:0] vcount;
  logic             hsync;
  logic             vsync;
  logic             bright;
  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic             line_start;
  logic             frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0]      frame_count;

  modport master (output pix_ce, hcount, vcount, hsync, vsync, bright, x, y, line_start,
                  frame_start, frame_count);
  modport slave  (input  pix_ce, hcount, vcount, hsync, vsync, bright, x, y, line_start,
                  frame_start, frame_count);
`else
  modport master (output pix_ce, hcount, vcount, hsync, vsync, bright, x, y, line_start,
                  frame_start);
  modport slave  (input  pix_ce, hcount, vcount, hsync, vsync, bright, x, y, line_start,
                  frame_start);
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator, single clk domain.
// A clk divider produces a one-cycle pixel clock-enable; horizontal/vertical counters advance
// on it and all decoded outputs (sync, bright, x, y, strobes) are registered from the next
// counter values so they change on the same edge as hcount/vcount.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-low reset
//   en    : run enable; low freezes divider, counters and decoded outputs, masks strobes
//   vga   : vga_timing_if master (pix_ce, hcount, vcount, hsync, vsync, bright, x, y,
//           line_start, frame_start[, frame_count])
// Optional feature: define VGA_TIMING_FRAME_CNT_EN to add a 16-bit wrapping frame counter.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CNT_W    = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  vga_timing_if.master vga
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned H_START = H_SYNC + H_BP;
  localparam int unsigned H_END   = H_START + H_ACTIVE;
  localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int unsigned V_START = V_SYNC + V_BP;
  localparam int unsigned V_END   = V_START + V_ACTIVE;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DivLast = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HLast   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] VLast   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] HStart  = CNT_W'(H_START);
  localparam logic [CNT_W-1:0] VStart  = CNT_W'(V_START);

  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] hcount_q, hcount_d, vcount_q, vcount_d;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
  logic             hsync_q, hsync_d, vsync_q, vsync_d, bright_q, bright_d;
  logic             line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic             pix_ce, line_wrap, frame_wrap, h_act, v_act;

  // Gated by reset so pix_ce reads 0 while held in reset, even with CLK_DIV=1.
  assign pix_ce = en & reset & (div_q == DivLast);

  always_comb begin
    div_d      = div_q;
    hcount_d   = hcount_q;
    vcount_d   = vcount_q;
    line_wrap  = 1'b0;
    frame_wrap = 1'b0;
    if (en) begin
      div_d = (div_q == DivLast) ? '0 : div_q + 1'b1;
    end
    if (pix_ce) begin
      if (hcount_q == HLast) begin
        hcount_d   = '0;
        line_wrap  = 1'b1;
        frame_wrap = (vcount_q == VLast);
        vcount_d   = (vcount_q == VLast) ? '0 : vcount_q + 1'b1;
      end else begin
        hcount_d = hcount_q + 1'b1;
      end
    end
  end

  // Decode from the next counter values so registered outputs line up with the counters.
  always_comb begin
    h_act         = (32'(hcount_d) >= H_START) && (32'(hcount_d) < H_END);
    v_act         = (32'(vcount_d) >= V_START) && (32'(vcount_d) < V_END);
    hsync_d       = (32'(hcount_d) < H_SYNC) ? HS_POL : ~HS_POL;
    vsync_d       = (32'(vcount_d) < V_SYNC) ? VS_POL : ~VS_POL;
    bright_d      = h_act && v_act;
    x_d           = bright_d ? hcount_d - HStart : '0;
    y_d           = bright_d ? vcount_d - VStart : '0;
    line_start_d  = line_wrap;
    frame_start_d = frame_wrap;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q         <= '0;
      hcount_q      <= '0;
      vcount_q      <= '0;
      hsync_q       <= HS_POL;
      vsync_q       <= VS_POL;
      bright_q      <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      bright_q      <= bright_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga.pix_ce      = pix_ce;
  assign vga.hcount      = hcount_q;
  assign vga.vcount      = vcount_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.bright      = bright_q;
  assign vga.x           = x_q;
  assign vga.y           = y_q;
  // Strobes read 0 whenever timing is frozen.
  assign vga.line_start  = line_start_q & en;
  assign vga.frame_start = frame_start_q & en;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_count_q, frame_count_d;

  // Bumps on the edge that raises frame_start; wraps naturally at 16 bits.
  always_comb begin
    frame_count_d = frame_count_q;
    if (frame_wrap) begin
      frame_count_d = frame_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_count_q <= '0;
    end else begin
      frame_count_q <= frame_count_d;
    end
  end

  assign vga.frame_count = frame_count_q;
`else
  // No frame counter in this build.
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen. Four instances share one clock and reset:
//   0 def : default 640x480 timing, CLK_DIV=4 (divider, line wrap, en freeze, reset mid-line)
//   1 dm1 : default geometry, CLK_DIV=1 (active-area boundaries within a short run)
//   2 alt : 800x600, CLK_DIV=1, active-high syncs
//   3 sml : tiny 16x9 raster, CLK_DIV=2 (frame wrap and strobes)
// Expected values are pushed into exp_q keyed by clk cycle; the monitor compares on negedge.
module tb_vga_timing_gen;

  localparam int SigHc = 0, SigVc = 1, SigPce = 2, SigHs = 3, SigVs = 4, SigBr = 5;
  localparam int SigX = 6, SigY = 7, SigLs = 8, SigFs = 9, SigFc = 10;

  typedef struct {
    int unsigned cyc;
    int          inst;
    int          sig;
    int unsigned val;
    string       name;
  } exp_t;

  typedef struct {
    int unsigned cyc;
    int unsigned vc;
  } ln_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en_def = 1'b1;
  logic        en_on = 1'b1;
  int unsigned gcyc = 0;
  int unsigned r0 = 0;
  int unsigned r1 = 0;
  int          total = 0;
  int          bad = 0;
  exp_t        exp_q[$];
  ln_t         line_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) gcyc <= gcyc + 1;

  vga_timing_if #(.CNT_W(10)) if_def ();
  vga_timing_if #(.CNT_W(10)) if_dm1 ();
  vga_timing_if #(.CNT_W(11)) if_alt ();
  vga_timing_if #(.CNT_W(5))  if_sml ();

  vga_timing_gen #(.CLK_DIV(4)) u_def (.clk(clk), .reset(rst_n), .en(en_def), .vga(if_def));
  vga_timing_gen #(.CLK_DIV(1)) u_dm1 (.clk(clk), .reset(rst_n), .en(en_on), .vga(if_dm1));
  vga_timing_gen #(
    .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
    .V_ACTIVE(600), .V_FP(1), .V_SYNC(4), .V_BP(23),
    .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(1), .CNT_W(11)
  ) u_alt (.clk(clk), .reset(rst_n), .en(en_on), .vga(if_alt));
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .CLK_DIV(2), .CNT_W(5)
  ) u_sml (.clk(clk), .reset(rst_n), .en(en_on), .vga(if_sml));

  function automatic logic [31:0] sig_of(int inst, int sig);
    logic [31:0] v [11];
    case (inst)
      0: v = '{32'(if_def.hcount), 32'(if_def.vcount), 32'(if_def.pix_ce), 32'(if_def.hsync),
               32'(if_def.vsync), 32'(if_def.bright), 32'(if_def.x), 32'(if_def.y),
               32'(if_def.line_start), 32'(if_def.frame_start), 32'd0};
      1: v = '{32'(if_dm1.hcount), 32'(if_dm1.vcount), 32'(if_dm1.pix_ce), 32'(if_dm1.hsync),
               32'(if_dm1.vsync), 32'(if_dm1.bright), 32'(if_dm1.x), 32'(if_dm1.y),
               32'(if_dm1.line_start), 32'(if_dm1.frame_start), 32'd0};
      2: v = '{32'(if_alt.hcount), 32'(if_alt.vcount), 32'(if_alt.pix_ce), 32'(if_alt.hsync),
               32'(if_alt.vsync), 32'(if_alt.bright), 32'(if_alt.x), 32'(if_alt.y),
               32'(if_alt.line_start), 32'(if_alt.frame_start), 32'd0};
      default: v = '{32'(if_sml.hcount), 32'(if_sml.vcount), 32'(if_sml.pix_ce),
               32'(if_sml.hsync), 32'(if_sml.vsync), 32'(if_sml.bright), 32'(if_sml.x),
               32'(if_sml.y), 32'(if_sml.line_start), 32'(if_sml.frame_start), 32'd0};
    endcase
`ifdef VGA_TIMING_FRAME_CNT_EN
    v[10] = 32'(if_sml.frame_count);
`endif
    return v[sig];
  endfunction

  task automatic ex(int unsigned c, int inst, int sig, int unsigned val, string nm);
    exp_t e;
    e.cyc = c; e.inst = inst; e.sig = sig; e.val = val; e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic push_line(int unsigned c, int unsigned vc);
    ln_t l;
    l.cyc = c; l.vc = vc;
    line_q.push_back(l);
  endtask

  // Called at #1 after a posedge; returns at #1 after the edge that makes gcyc == c.
  task automatic goto(int unsigned c);
    while (gcyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compare every expectation due this cycle, and every line_start of u_def.
  always @(negedge clk) begin
    logic [31:0] got;
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc == gcyc) begin
        got = sig_of(exp_q[i].inst, exp_q[i].sig);
        total++;
        if (got != exp_q[i].val) begin
          bad++;
          $display("FAIL %s cyc=%0d got=%0d want=%0d", exp_q[i].name, gcyc - r0, got,
                   exp_q[i].val);
        end
        exp_q.delete(i);
      end
    end
    if (if_def.line_start) begin
      total++;
      if (line_q.size() == 0) begin
        bad++;
        $display("FAIL def_line_start unexpected cyc=%0d got=1 want=0", gcyc - r0);
      end else begin
        ln_t l;
        l = line_q.pop_front();
        if (l.cyc != gcyc || l.vc != 32'(if_def.vcount)) begin
          bad++;
          $display("FAIL def_line_start got cyc=%0d vc=%0d want cyc=%0d vc=%0d",
                   gcyc - r0, if_def.vcount, l.cyc - r0, l.vc);
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    r0 = gcyc;

    // def: divider start, hsync edge, line wrap, vsync edge
    ex(r0 + 0, 0, SigHc, 0, "def_rst_hc");     ex(r0 + 0, 0, SigPce, 0, "def_rst_pce");
    ex(r0 + 0, 0, SigHs, 0, "def_rst_hs");     ex(r0 + 0, 0, SigLs, 0, "def_rst_ls");
    ex(r0 + 2, 0, SigPce, 0, "def_c2_pce");    ex(r0 + 3, 0, SigPce, 1, "def_c3_pce");
    ex(r0 + 3, 0, SigHc, 0, "def_c3_hc");      ex(r0 + 4, 0, SigHc, 1, "def_c4_hc");
    ex(r0 + 4, 0, SigPce, 0, "def_c4_pce");    ex(r0 + 7, 0, SigPce, 1, "def_c7_pce");
    ex(r0 + 383, 0, SigHs, 0, "def_hs_h95");   ex(r0 + 384, 0, SigHs, 1, "def_hs_h96");
    ex(r0 + 576, 0, SigBr, 0, "def_br_v0");
    ex(r0 + 3199, 0, SigHc, 799, "def_h799");  ex(r0 + 3199, 0, SigLs, 0, "def_ls_pre");
    ex(r0 + 3200, 0, SigHc, 0, "def_wrap_hc"); ex(r0 + 3200, 0, SigVc, 1, "def_wrap_vc");
    ex(r0 + 3200, 0, SigLs, 1, "def_wrap_ls"); ex(r0 + 3200, 0, SigFs, 0, "def_wrap_fs");
    ex(r0 + 3201, 0, SigLs, 0, "def_ls_post"); ex(r0 + 3200, 0, SigVs, 0, "def_vs_v1");
    ex(r0 + 6399, 0, SigVs, 0, "def_vs_v1e");  ex(r0 + 6400, 0, SigVs, 1, "def_vs_v2");
    // def: en low in cycles 8402..8411 at hcount 500
    ex(r0 + 8401, 0, SigHc, 500, "def_en_hc0");
    ex(r0 + 8402, 0, SigPce, 0, "def_en_pce0");
    ex(r0 + 8403, 0, SigPce, 0, "def_en_pce1");
    ex(r0 + 8407, 0, SigPce, 0, "def_en_pce2");
    ex(r0 + 8411, 0, SigHc, 500, "def_en_hc1");
    ex(r0 + 8411, 0, SigPce, 0, "def_en_pce3");
    ex(r0 + 8413, 0, SigPce, 1, "def_res_pce");
    ex(r0 + 8413, 0, SigHc, 500, "def_res_hc0");
    ex(r0 + 8414, 0, SigHc, 501, "def_res_hc1");
    push_line(r0 + 3200, 1);
    push_line(r0 + 6400, 2);
    for (int i = 3; i <= 9; i++) push_line(r0 + 9610 + 32'(i - 3) * 3200, 32'(i));

    // dm1: active-area boundaries on line 35
    ex(r0 + 27344, 1, SigBr, 0, "dm1_br_v34");
    ex(r0 + 28143, 1, SigBr, 0, "dm1_br_h143");
    ex(r0 + 28144, 1, SigBr, 1, "dm1_br_h144"); ex(r0 + 28144, 1, SigX, 0, "dm1_x_h144");
    ex(r0 + 28144, 1, SigY, 0, "dm1_y_v35");
    ex(r0 + 28783, 1, SigBr, 1, "dm1_br_h783"); ex(r0 + 28783, 1, SigX, 639, "dm1_x_h783");
    ex(r0 + 28784, 1, SigBr, 0, "dm1_br_h784"); ex(r0 + 28784, 1, SigX, 0, "dm1_x_h784");

    // alt: 800x600, CLK_DIV=1, active-high syncs
    ex(r0 + 0, 2, SigPce, 1, "alt_pce_c0");    ex(r0 + 0, 2, SigHs, 1, "alt_hs_h0");
    ex(r0 + 0, 2, SigVs, 1, "alt_vs_v0");      ex(r0 + 500, 2, SigPce, 1, "alt_pce_c500");
    ex(r0 + 127, 2, SigHs, 1, "alt_hs_h127");  ex(r0 + 128, 2, SigHs, 0, "alt_hs_h128");
    ex(r0 + 1055, 2, SigHc, 1055, "alt_h1055");
    ex(r0 + 1056, 2, SigHc, 0, "alt_wrap_hc"); ex(r0 + 1056, 2, SigVc, 1, "alt_wrap_vc");
    ex(r0 + 1056, 2, SigLs, 1, "alt_wrap_ls"); ex(r0 + 1057, 2, SigLs, 0, "alt_ls_post");
    ex(r0 + 4223, 2, SigVs, 1, "alt_vs_v3");   ex(r0 + 4224, 2, SigVs, 0, "alt_vs_v4");

    // sml: 16x9 raster, CLK_DIV=2, frame = 288 cycles
    ex(r0 + 32, 3, SigLs, 1, "sml_line_ls");   ex(r0 + 32, 3, SigFs, 0, "sml_line_fs");
    ex(r0 + 32, 3, SigVc, 1, "sml_line_vc");
    ex(r0 + 63, 3, SigVs, 0, "sml_vs_v1");     ex(r0 + 64, 3, SigVs, 1, "sml_vs_v2");
    ex(r0 + 139, 3, SigBr, 0, "sml_br_h5");    ex(r0 + 140, 3, SigBr, 1, "sml_br_h6");
    ex(r0 + 140, 3, SigX, 0, "sml_x_h6");      ex(r0 + 140, 3, SigY, 0, "sml_y_v4");
    ex(r0 + 154, 3, SigX, 7, "sml_x_h13");     ex(r0 + 156, 3, SigBr, 0, "sml_br_h14");
    ex(r0 + 156, 3, SigX, 0, "sml_x_h14");
    ex(r0 + 238, 3, SigX, 1, "sml_x_v7");      ex(r0 + 238, 3, SigY, 3, "sml_y_v7");
    ex(r0 + 270, 3, SigBr, 0, "sml_br_v8");    ex(r0 + 270, 3, SigY, 0, "sml_y_v8");
    ex(r0 + 287, 3, SigHc, 15, "sml_end_hc");  ex(r0 + 287, 3, SigVc, 8, "sml_end_vc");
    ex(r0 + 287, 3, SigFs, 0, "sml_end_fs");
    ex(r0 + 288, 3, SigHc, 0, "sml_fw_hc");    ex(r0 + 288, 3, SigVc, 0, "sml_fw_vc");
    ex(r0 + 288, 3, SigLs, 1, "sml_fw_ls");    ex(r0 + 288, 3, SigFs, 1, "sml_fw_fs");
    ex(r0 + 289, 3, SigLs, 0, "sml_fw_ls1");   ex(r0 + 289, 3, SigFs, 0, "sml_fw_fs1");
    ex(r0 + 576, 3, SigFs, 1, "sml_fw2_fs");
`ifdef VGA_TIMING_FRAME_CNT_EN
    ex(r0 + 287, 3, SigFc, 0, "sml_fc0");      ex(r0 + 288, 3, SigFc, 1, "sml_fc1");
    ex(r0 + 576, 3, SigFc, 2, "sml_fc2");
`endif

    // Just before the mid-line reset, then the reset cycle itself
    ex(r0 + 29000, 0, SigHc, 47, "def_pre_hc"); ex(r0 + 29000, 0, SigVc, 9, "def_pre_vc");
    ex(r0 + 29000, 1, SigBr, 1, "dm1_pre_br");  ex(r0 + 29000, 1, SigX, 56, "dm1_pre_x");
    ex(r0 + 29000, 1, SigY, 1, "dm1_pre_y");
    ex(r0 + 29000, 2, SigVc, 27, "alt_pre_vc"); ex(r0 + 29000, 2, SigBr, 1, "alt_pre_br");
    ex(r0 + 29000, 2, SigX, 272, "alt_pre_x");  ex(r0 + 29000, 2, SigY, 0, "alt_pre_y");
    for (int s = SigHc; s <= SigFs; s++) ex(r0 + 29001, 0, s, 0, "def_rstmid");
    ex(r0 + 29001, 1, SigBr, 0, "dm1_rst_br");  ex(r0 + 29001, 1, SigX, 0, "dm1_rst_x");
    ex(r0 + 29001, 1, SigY, 0, "dm1_rst_y");    ex(r0 + 29001, 1, SigPce, 0, "dm1_rst_pce");
    ex(r0 + 29001, 2, SigHs, 1, "alt_rst_hs");  ex(r0 + 29001, 2, SigVs, 1, "alt_rst_vs");
    ex(r0 + 29001, 2, SigPce, 0, "alt_rst_pce"); ex(r0 + 29001, 2, SigHc, 0, "alt_rst_hc");
    ex(r0 + 29001, 3, SigHc, 0, "sml_rst_hc");  ex(r0 + 29001, 3, SigVc, 0, "sml_rst_vc");
`ifdef VGA_TIMING_FRAME_CNT_EN
    ex(r0 + 29001, 3, SigFc, 0, "sml_rst_fc");
`endif

    goto(r0 + 8402);
    en_def = 1'b0;
    goto(r0 + 8412);
    en_def = 1'b1;
    goto(r0 + 29001);
    rst_n = 1'b0;
    goto(r0 + 29003);
    rst_n = 1'b1;
    r1 = gcyc;

    // Restart from (0,0) with no strobe for the reset position
    ex(r1 + 0, 0, SigHc, 0, "def_rel_hc");     ex(r1 + 0, 0, SigPce, 0, "def_rel_pce");
    ex(r1 + 0, 0, SigLs, 0, "def_rel_ls");     ex(r1 + 0, 0, SigFs, 0, "def_rel_fs");
    ex(r1 + 2, 0, SigPce, 0, "def_rel_c2");    ex(r1 + 3, 0, SigPce, 1, "def_rel_c3");
    ex(r1 + 3, 0, SigHc, 0, "def_rel_c3hc");   ex(r1 + 4, 0, SigHc, 1, "def_rel_c4hc");
    ex(r1 + 4, 0, SigPce, 0, "def_rel_c4");
    ex(r1 + 0, 2, SigPce, 1, "alt_rel_pce");   ex(r1 + 1, 2, SigHc, 1, "alt_rel_hc");
    ex(r1 + 0, 3, SigFs, 0, "sml_rel_fs");     ex(r1 + 0, 3, SigLs, 0, "sml_rel_ls");
    ex(r1 + 1, 3, SigPce, 1, "sml_rel_pce");   ex(r1 + 2, 3, SigHc, 1, "sml_rel_hc");

    goto(r1 + 10);
    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover_checks got=%0d want=0", exp_q.size());
    end
    total++;
    if (line_q.size() != 0) begin
      bad++;
      $display("FAIL missing_line_start got=%0d want=0", line_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator that replaces the fixed 640x480 controller. It generates horizontal and vertical counters, sync pulses, the active-video flag and active-area pixel coordinates, and provides line and frame strobes for the pixel and game logic. All logic runs in a single `clk` domain. A pixel clock-enable replaces divided clocks, and mode, porch widths and sync polarity are set by parameters.

## Interface
- `H_ACTIVE`, 640: active pixels per line
- `H_FP`, 16: horizontal front porch, in pixels
- `H_SYNC`, 96: horizontal sync width, in pixels
- `H_BP`, 48: horizontal back porch, in pixels
- `V_ACTIVE`, 480: active lines per frame
- `V_FP`, 10: vertical front porch, in lines
- `V_SYNC`, 2: vertical sync width, in lines
- `V_BP`, 33: vertical back porch, in lines
- `HS_POL`, 0: hsync active level (0 = active-low)
- `VS_POL`, 0: vsync active level (0 = active-low)
- `CLK_DIV`, 4: `clk` cycles per pixel, must be ≥1
- `CNT_W`, 10: counter width; must hold `H_TOTAL-1` and `V_TOTAL-1`
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `en`  in  1  run enable; low freezes timing
- `pix_ce`  out  1  pixel clock-enable, one `clk` wide
- `hcount`  out  CNT_W  horizontal position, 0..H_TOTAL-1
- `vcount`  out  CNT_W  vertical position, 0..V_TOTAL-1
- `hsync`  out  1  horizontal sync, polarity set by `HS_POL`
- `vsync`  out  1  vertical sync, polarity set by `VS_POL`
- `bright`  out  1  active-video flag
- `x`  out  CNT_W  active-area column; 0 when `bright`=0
- `y`  out  CNT_W  active-area row; 0 when `bright`=0
- `line_start`  out  1  one-`clk` pulse when `hcount` becomes 0
- `frame_start`  out  1  one-`clk` pulse when `hcount` and `vcount` both become 0

## Operation
- Derived constants:
  - `H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP`
  - `H_START = H_SYNC+H_BP`
  - V equivalents are defined the same way.
- Region order along each axis: sync `[0,SYNC)`, back porch, active `[START,START+ACTIVE)`, front porch.
- Divider:
  - `div` counts 0..CLK_DIV-1 on each `clk` edge while `en`=1.
  - `pix_ce = en && (div == CLK_DIV-1)`.
  - With `CLK_DIV`=1, `pix_ce` equals `en`.
- On each `clk` edge with `pix_ce`=1:
  - `hcount` increments and wraps from `H_TOTAL-1` to 0.
  - On the `hcount` wrap, `vcount` increments and wraps from `V_TOTAL-1` to 0.
- Decoded outputs are registered, computed from the next counter values so they stay coherent with `hcount`/`vcount` in the same cycle:
  - `hsync = HS_POL` when `hcount < H_SYNC`, else `~HS_POL`.
  - `vsync` is decoded the same way from `vcount`, `V_SYNC` and `VS_POL`.
  - `bright = 1` when `hcount` and `vcount` are both in their active ranges.
  - `x = hcount-H_START` and `y = vcount-V_START` when `bright`=1, else both 0.
- `line_start` and `frame_start` are high only in the single `clk` cycle in which the new counter value is first presented.
- `en`=0:
  - `div` and all counters hold.
  - `pix_ce`, `line_start` and `frame_start` read 0.
  - Sync, `bright`, `x` and `y` hold their values.
- `reset` low, at any time including mid-frame:
  - `div`=0, `hcount`=0, `vcount`=0.
  - `hsync`=HS_POL, `vsync`=VS_POL.
  - `bright`=0, `x`=0, `y`=0.
  - `line_start`=0, `frame_start`=0, `pix_ce`=0.
  - Timing resumes from (0,0) on release, with no strobe for the reset position.

## Timing
- With `CLK_DIV`=4 and `en`=1 after reset release, `pix_ce` is high in `clk` cycles 3, 7, 11, … (cycle 0 is the first edge after release).
- `hcount` changes on the edge that closes each `pix_ce` cycle.
- Latency from a counter edge to its decoded outputs is 0 cycles; all outputs change on the same edge.
- A line lasts `H_TOTAL*CLK_DIV` `clk` cycles. A frame lasts `H_TOTAL*V_TOTAL*CLK_DIV` `clk` cycles.
- Simultaneous H and V wrap: `line_start` and `frame_start` assert in the same cycle.

## Configuration
- `VGA_TIMING_FRAME_CNT_EN`
- Defined:
  - Adds output `frame_count` [15:0], reset value 0.
  - `frame_count` increments in the cycle `frame_start` asserts and wraps 0xFFFF→0.
  - It holds while `en`=0.
- Undefined: the port and counter are absent, and all other behaviour is identical.

## Test plan
- Reset values: assert `reset` low mid-line at `hcount`=300, `vcount`=200 → all outputs at reset values in that cycle; after release, the first `pix_ce` occurs at cycle 3 and `hcount`=1 at cycle 4.
- Default mode, horizontal: `hsync`=0 for `hcount` 0..95, `bright`=1 for `hcount` 144..783 with `vcount` 35..514, `x`=0 at `hcount`=144, `x`=639 at `hcount`=783.
- Line wrap: `hcount` 799→0 → `vcount` +1 and `line_start` high for exactly 1 `clk`; `vsync`=0 only for `vcount` 0..1.
- Frame wrap: (799,524)→(0,0) → `line_start`=`frame_start`=1 in the same cycle; with the macro defined, `frame_count` 0→1, and 0xFFFF→0 on forced wrap.
- `en` low for 10 cycles at `hcount`=500 → `hcount` stays 500, `pix_ce` stays 0; resuming adds exactly 10 cycles to the line period.
- Alternate parameters: `CLK_DIV`=1, `HS_POL`=`VS_POL`=1, 800x600 (40/128/88, 1/4/23) → `pix_ce` constantly 1, `hsync`=1 for `hcount` 0..127, frame = 1056x628 cycles.
